// File: rtl/mips_pkg.sv
// Shared encodings and widths for the EX-stage multiply/divide unit.
package mips_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned STEPS = WIDTH;
   localparam int unsigned CNT_W = $clog2(STEPS);

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } muldiv_state_t;

   // Magnitude of x when treated as signed; raw value otherwise.
   function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x,
                                              input logic              sgn);
      return (sgn && x[WIDTH-1]) ? WIDTH'(~x + WIDTH'(1)) : x;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step
   import mips_pkg::*;
(
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] opd,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;
   logic           fits;

   // Multiply: {hi,lo} holds partial product and remaining multiplier bits.
   // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
   always_comb begin
      sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
      rem_sh = {acc_hi, acc_lo[WIDTH-1]};
      fits   = (rem_sh >= {1'b0, opd});
      hi_nxt = '0;
      lo_nxt = '0;
      if (is_div) begin
         hi_nxt = fits ? WIDTH'(rem_sh - {1'b0, opd}) : rem_sh[WIDTH-1:0];
         lo_nxt = {acc_lo[WIDTH-2:0], fits};
      end else begin
         hi_nxt = sum[WIDTH:1];
         lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
module ex_muldiv
   import mips_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       op,
   input  logic             start,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   muldiv_state_t    state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opd;
   logic [WIDTH-1:0] a_raw;
   logic             neg_res;
   logic             neg_rem;
   logic             is_div;
   logic             div_zero;

   logic [WIDTH-1:0]   step_hi;
   logic [WIDTH-1:0]   step_lo;
   logic               op_signed;
   logic               op_div;
   logic               op_md;
   logic               sgn_a;
   logic               sgn_b;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   muldiv_step u_step (
      .is_div (is_div),
      .acc_hi (acc_hi),
      .acc_lo (acc_lo),
      .opd    (opd),
      .hi_nxt (step_hi),
      .lo_nxt (step_lo)
   );

   // Decode the incoming request and form operand magnitudes.
   always_comb begin
      op_signed = (op == OP_MULT) || (op == OP_DIV);
      op_div    = (op == OP_DIV)  || (op == OP_DIVU);
      op_md     = (op == OP_MULT) || (op == OP_MULTU) || op_div;
      sgn_a     = op_signed && opa[WIDTH-1];
      sgn_b     = op_signed && opb[WIDTH-1];
      abs_a     = abs_w(opa, op_signed);
      abs_b     = abs_w(opb, op_signed);
   end

   // Sign correction of the unsigned iteration result.
   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_fix = neg_res ? (2*WIDTH)'(~prod + (2*WIDTH)'(1)) : prod;
      quo_fix  = neg_res ? WIDTH'(~acc_lo + WIDTH'(1)) : acc_lo;
      rem_fix  = neg_rem ? WIDTH'(~acc_hi + WIDTH'(1)) : acc_hi;
   end

   // Control FSM, iteration state and HI/LO, all updated on the falling edge.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opd      <= '0;
         a_raw    <= '0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         is_div   <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !flush) begin
                  if (op_md) begin
                     state    <= ST_CALC;
                     busy     <= 1'b1;
                     cnt      <= '0;
                     acc_hi   <= '0;
                     acc_lo   <= op_div ? abs_a : abs_b;
                     opd      <= op_div ? abs_b : abs_a;
                     a_raw    <= opa;
                     neg_res  <= sgn_a ^ sgn_b;
                     neg_rem  <= sgn_a;
                     is_div   <= op_div;
                     div_zero <= op_div && (opb == '0);
                  end else if (op == OP_MTHI) begin
                     hi <= opa;
                  end else if (op == OP_MTLO) begin
                     lo <= opa;
                  end
               end
            end
            ST_CALC: begin
               if (flush) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  acc_hi <= step_hi;
                  acc_lo <= step_lo;
                  cnt    <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(STEPS - 1)) begin
                     state <= ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               if (!flush) begin
                  done <= 1'b1;
                  if (!is_div) begin
                     hi <= prod_fix[2*WIDTH-1:WIDTH];
                     lo <= prod_fix[WIDTH-1:0];
                  end else if (div_zero) begin
                     hi <= a_raw;
                     lo <= '1;
                  end else begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed bench for ex_muldiv against an arithmetic reference.
module tb_ex_muldiv;

   logic        clk;
   logic        rst_n;
   logic [2:0]  op;
   logic        start;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   ex_muldiv dut (
      .clk   (clk),
      .rst_n (rst_n),
      .op    (op),
      .start (start),
      .opa   (opa),
      .opb   (opb),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result {hi, lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, b, h, l);
      logic signed [63:0] sa, sb, p, q, r;
      logic [63:0] u;
      sa = $signed(a);
      sb = $signed(b);
      case (o)
         3'd1: begin p = sa * sb; return p; end
         3'd2: begin u = {32'b0, a} * {32'b0, b}; return u; end
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd4: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
         3'd5: return {a, l};
         3'd6: return {h, a};
         default: return {h, l};
      endcase
   endfunction

   task automatic run_op(input string name, input logic [2:0] o,
                         input logic [31:0] a, b, input bit intrude);
      int busy_cnt, done_cnt, done_at;
      logic [63:0] r;
      r = model(o, a, b, exp_hi, exp_lo);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      @(posedge clk);
      op = o; opa = a; opb = b; start = 1'b1;
      @(posedge clk);
      start = 1'b0; op = 3'd0;
      busy_cnt = 0; done_cnt = 0; done_at = -1;
      for (int k = 0; k < 40; k++) begin
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin done_cnt++; done_at = k; end
         if (intrude && k == 5) begin start = 1'b1; op = 3'd2; opa = 32'h1; opb = 32'h1; end
         if (intrude && k == 6) begin start = 1'b0; op = 3'd0; end
         @(posedge clk);
      end
      checks++; if (busy_cnt != 33) begin errors++; $display("FAIL %s busy_cycles: got %0d expected 33", name, busy_cnt); end
      checks++; if (done_cnt != 1 || done_at != 33) begin errors++; $display("FAIL %s done_pulse: got count %0d at %0d expected 1 at 33", name, done_cnt, done_at); end
      checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s hi: got %h expected %h", name, hi, exp_hi); end
      checks++; if (lo !== exp_lo) begin errors++; $display("FAIL %s lo: got %h expected %h", name, lo, exp_lo); end
   endtask

   task automatic run_mt(input string name, input logic [2:0] o, input logic [31:0] a);
      logic [63:0] r;
      r = model(o, a, 32'd0, exp_hi, exp_lo);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      @(posedge clk);
      op = o; opa = a; start = 1'b1;
      @(posedge clk);
      start = 1'b0; op = 3'd0;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s status: got busy %b done %b expected 0 0", name, busy, done); end
      checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL %s hilo: got %h_%h expected %h_%h", name, hi, lo, exp_hi, exp_lo); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; op = 3'd0; start = 1'b0; opa = '0; opb = '0; flush = 1'b0;
      repeat (2) @(posedge clk);
      checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h_%h expected 0", hi, lo); end
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_status: got %b%b expected 00", busy, done); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      checks++; if ({hi, lo, busy, done} !== 66'd0) begin errors++; $display("FAIL reset_release: got %h_%h %b%b expected zeros", hi, lo, busy, done); end
   endtask

   task automatic test_directed();
      run_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      checks++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_max_const: got %h_%h expected fffffffe_00000001", hi, lo); end
      run_op("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd7, 1'b0);
      checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mult_neg_const: got %h_%h expected ffffffff_ffffffeb", hi, lo); end
      run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
      checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg_const: got %h_%h expected ffffffff_fffffffd", hi, lo); end
      run_op("divu_zero", 3'd4, 32'd100, 32'd0, 1'b0);
      checks++; if ({hi, lo} !== 64'h00000064_FFFFFFFF) begin errors++; $display("FAIL divu_zero_const: got %h_%h expected 00000064_ffffffff", hi, lo); end
      run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      checks++; if ({hi, lo} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_ovf_const: got %h_%h expected 00000000_80000000", hi, lo); end
      run_op("div_zero_neg", 3'd3, 32'hFFFFFF00, 32'd0, 1'b0);
   endtask

   task automatic test_mt_consecutive();
      bit saw_busy;
      saw_busy = 1'b0;
      @(posedge clk);
      op = 3'd5; opa = 32'h12345678; start = 1'b1;
      @(posedge clk);
      saw_busy |= busy;
      checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi: got %h expected 12345678", hi); end
      op = 3'd6; opa = 32'h9ABCDEF0;
      @(posedge clk);
      saw_busy |= busy;
      start = 1'b0; op = 3'd0;
      checks++; if (lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo: got %h expected 9abcdef0", lo); end
      checks++; if (saw_busy || done !== 1'b0) begin errors++; $display("FAIL mt_busy: got busy_seen %b done %b expected 0 0", saw_busy, done); end
      exp_hi = 32'h12345678;
      exp_lo = 32'h9ABCDEF0;
   endtask

   task automatic test_flush();
      int done_cnt;
      @(posedge clk);
      op = 3'd4; opa = 32'd1000; opb = 32'd7; start = 1'b1;
      @(posedge clk);
      start = 1'b0; op = 3'd0;
      repeat (9) @(posedge clk);
      flush = 1'b1;
      @(posedge clk);
      flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
      done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (done === 1'b1) done_cnt++;
         @(posedge clk);
      end
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL flush_done: got %0d pulses expected 0", done_cnt); end
      checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL flush_hilo: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo); end
      run_op("multu_after_flush", 3'd2, 32'd3, 32'd5, 1'b0);
      checks++; if ({hi, lo} !== 64'd15) begin errors++; $display("FAIL multu_after_flush_const: got %h_%h expected 0_f", hi, lo); end
   endtask

   task automatic test_flush_idle();
      @(posedge clk);
      op = 3'd5; opa = 32'hDEADBEEF; start = 1'b1; flush = 1'b1;
      @(posedge clk);
      op = 3'd1; opb = 32'd3;
      @(posedge clk);
      start = 1'b0; flush = 1'b0; op = 3'd0;
      checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL flush_idle_hilo: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      run_op("b2b_first", 3'd1, 32'h00012345, 32'hFFFF0001, 1'b1);
      run_op("b2b_second", 3'd3, 32'd1000, 32'hFFFFFFF9, 1'b0);
      run_op("b2b_third", 3'd4, 32'hFFFFFFFF, 32'd3, 1'b0);
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         o = 3'($urandom_range(1, 6));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: a = 32'h80000000;
            default: ;
         endcase
         if (o >= 3'd5) run_mt("rand_mt", o, a);
         else           run_op("rand_op", o, a, b, 1'b0);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      op = 3'd2; opa = 32'h55; opb = 32'h77; start = 1'b1;
      @(posedge clk);
      start = 1'b0; op = 3'd0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL async_rst_hilo: got %h_%h expected 0", hi, lo); end
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL async_rst_status: got %b%b expected 00", busy, done); end
      exp_hi = '0;
      exp_lo = '0;
      @(posedge clk);
      rst_n = 1'b1;
      run_op("after_reset", 3'd2, 32'd3, 32'd5, 1'b0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mt_consecutive();
      test_flush();
      test_flush_idle();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the decoded mult/div operation and the two register operands (rs, rt) and owns the architectural HI/LO registers. It raises a stall to the front end while a 32-step operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width
STEPS, 32, iteration count, fixed equal to WIDTH

Ports:
clk  in  1  pipeline clock; all state updates on negedge clk, matching the pipeline registers
rst_n  in  1  asynchronous active-low reset
op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
start  in  1  op/operands valid this cycle, from the ID/EX register
opa  in  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO source)
opb  in  WIDTH  rt value (divisor / multiplier)
flush  in  1  abort any in-flight operation (branch/jump squash)
busy  out  1  operation in flight; front end stalls, MFHI/MFLO must wait
done  out  1  one-cycle pulse: HI/LO just updated by mult/div
hi  out  WIDTH  architectural HI
lo  out  WIDTH  architectural LO

Behaviour:
- Reset (async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0.
- States: IDLE, CALC, FIX.
- IDLE, start=1, op in {1..4}: latch |opa|, |opb| for signed ops (raw values for unsigned), record result signs, counter=0 -> CALC. busy=1 from this edge.
- IDLE, start=1, op=5/6: hi<=opa / lo<=opa on that edge; stay IDLE; busy stays 0; done stays 0.
- IDLE, op=0 or start=0: no change.
- CALC: one radix-2 step per edge (shift-add for multiply, restoring shift-subtract for divide), counter+1; after step STEPS-1 -> FIX.
- FIX: apply sign correction, write hi/lo, busy<=0, done<=1 for exactly one cycle -> IDLE. Results visible 33 edges after the accepting edge.
- Signed multiply: 64-bit product negated when operand signs differ; hi=upper, lo=lower word.
- Signed divide: quotient negated when signs differ; remainder takes sign of dividend. lo=quotient, hi=remainder.
- 0x80000000 DIV 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
- Divide by zero (DIV/DIVU): no iteration result used; FIX writes lo=0xFFFFFFFF, hi=opa as latched; same latency.
- start while busy: ignored (upstream is stalled and holds its register).
- flush: in CALC or FIX returns to IDLE on the next edge, hi/lo unchanged, busy<=0, no done. flush with start in IDLE: request ignored, including MTHI/MTLO. flush has priority over all else except reset.
- Same-cycle start and done: impossible, since start is accepted only in IDLE.

Decomposition:
- Shared package mips_pkg: muldiv_op_t enum (the 3-bit encodings above), muldiv_state_t, WIDTH constant.
- One natural sub-module: muldiv_step, the combinational single-iteration datapath (add/sub plus shift) instantiated once and selected by operation type. FSM, counter, sign fix and HI/LO stay in ex_muldiv.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high 33 cycles; done pulse once; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> after 33 edges lo=0xFFFFFFFF, hi=0x00000064; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> each applied on its edge, busy never asserted.
- DIVU 1000/7 with flush on the 10th CALC cycle -> busy low next edge, no done, hi/lo keep prior values; a fresh MULTU 3x5 then gives lo=15, hi=0.
- rst_n low mid-CALC -> hi=lo=0, busy=0, done=0 immediately, without waiting for a clock edge.
